// File: rtl/addsub_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_share_pkg
//  Description : Shared definitions for the add/subtract sharing controller:
//                FSM state encodings, requester port ids and the signed
//                overflow helper used by the add stage.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_share_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NEG  = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic PORT_ALU = 1'b0;
    localparam logic PORT_BR  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_NEG  = S_NEG,
        ST_ADD  = S_ADD,
        ST_HOLD = S_HOLD
    } state_e;

    // Signed overflow from sign bits. b_msb is the ORIGINAL operand B sign,
    // so for SUB the condition is "A and B differ in sign" and for ADD it is
    // "A and B share a sign"; in both cases the sum sign must differ from A.
    // Using the original B keeps B=0x80 (whose negation is itself) correct.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic sub);
        return ((a_msb ^ b_msb) == sub) && (s_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_share_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_share_ctrl_if
//  Description : Request/result bundle for the shared add/subtract unit.
//                Two requester ports (valid/ready, A, B, SUB) and one result
//                port (valid/ready, data, id, zero, overflow).
//  Modports    : master - requesters and result consumer side
//                slave  - the controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface addsub_share_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_zero;
    logic             res_ovf;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id, res_zero, res_ovf
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id, res_zero, res_ovf
    );
endinterface
`default_nettype wire

// File: rtl/addsub_share_ctrl_neg.sv
`default_nettype none
// ============================================================================
//  Module      : twos_neg
//  Description : Combinational two's-complement negator, (~x + 1) mod 2^W.
//  Ports       : in_i  [WIDTH] - operand
//                out_o [WIDTH] - negated operand
//  Revision    : 1.0 - initial release
// ============================================================================
module twos_neg #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);
    assign out_o = ~in_i + {{(WIDTH-1){1'b0}}, 1'b1};
endmodule
`default_nettype wire

// File: rtl/addsub_share_ctrl_rr_grant2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant2
//  Description : Two-input round-robin grant. The pointed-to requester wins
//                a tie; on advance the pointer moves to the port that was not
//                granted. Grant is combinational, pointer is registered.
//  Ports       : clk_i      - clock
//                rst_ni     - synchronous active-low reset (pointer -> 0)
//                req_i[1:0] - requests (already qualified by the caller)
//                advance_i  - a grant was consumed this cycle
//                gnt_o[1:0] - one-hot (or zero) grant
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);
    logic ptr_q;

    assign gnt_o[0] = req_i[0] & (~ptr_q | ~req_i[1]);
    assign gnt_o[1] = req_i[1] & ( ptr_q | ~req_i[0]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (advance_i) begin
            // Port 0 served -> point at port 1, and vice versa.
            ptr_q <= gnt_o[0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/addsub_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_share_ctrl
//  Description : Shares one adder and one negator between two requesters
//                (port 0 = ALU add/sub, port 1 = branch offset / PC adjust).
//                SUB runs as a registered negate stage then an add stage;
//                the result is held until the consumer accepts it.
//  Ports       : clk_i  - clock, all state on rising edge
//                rst_ni - synchronous active-low reset
//                bus    - addsub_share_ctrl_if.slave (requests + result)
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_share_ctrl
    import addsub_share_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    addsub_share_ctrl_if.slave   bus
);
    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             b_msb_q;
    logic             sub_q;
    logic             id_q;

    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;
    logic             res_zero_q;
    logic             res_ovf_q;

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             take;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_sub;
    logic [WIDTH-1:0] neg_b;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    // Requests only count in IDLE and out of reset; READY is the grant itself.
    assign req  = (state_q == ST_IDLE && rst_ni) ? {bus.req1_valid, bus.req0_valid} : 2'b00;
    assign take = |gnt;

    rr_grant2 u_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req),
        .advance_i (take),
        .gnt_o     (gnt)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    assign sel_a   = gnt[1] ? bus.req1_a   : bus.req0_a;
    assign sel_b   = gnt[1] ? bus.req1_b   : bus.req0_b;
    assign sel_sub = gnt[1] ? bus.req1_sub : bus.req0_sub;

    twos_neg #(.WIDTH(WIDTH)) u_neg (
        .in_i  (b_q),
        .out_o (neg_b)
    );

    assign sum_d = a_q + b_q;
    assign ovf_d = ovf_flag(a_q[WIDTH-1], b_msb_q, sum_d[WIDTH-1], sub_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            b_msb_q     <= 1'b0;
            sub_q       <= 1'b0;
            id_q        <= PORT_ALU;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= PORT_ALU;
            res_zero_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        b_msb_q <= sel_b[WIDTH-1];
                        sub_q   <= sel_sub;
                        id_q    <= gnt[1] ? PORT_BR : PORT_ALU;
                        state_q <= sel_sub ? ST_NEG : ST_ADD;
                    end
                end
                ST_NEG: begin
                    b_q     <= neg_b;
                    state_q <= ST_ADD;
                end
                ST_ADD: begin
                    res_data_q  <= sum_d;
                    res_id_q    <= id_q;
                    res_zero_q  <= (sum_d == '0);
                    res_ovf_q   <= ovf_d;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_ovf   = res_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_share_ctrl
//  Description : Directed self-checking bench for addsub_share_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_share_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic both_seen = 1'b0;

    always #5 clk = ~clk;

    addsub_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

    addsub_share_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.req0_ready && bus.req1_ready) both_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
        bus.res_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called just after a rising edge with the DUT in IDLE.
    task automatic do_op(input string tag, input bit port, input logic [7:0] a,
                         input logic [7:0] b, input bit sub, input logic [7:0] exp_d,
                         input bit exp_z, input bit exp_o);
        if (port) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
        end
        @(negedge clk);
        check({tag, "_ready"}, port ? bus.req1_ready : bus.req0_ready, 1);
        @(posedge clk);  // transfer edge
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (sub) begin
            check({tag, "_valid_neg"}, bus.res_valid, 0);
            @(posedge clk);
            #1;
        end
        check({tag, "_valid_early"}, bus.res_valid, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, bus.res_valid, 1);
        check({tag, "_data"},  bus.res_data,  exp_d);
        check({tag, "_id"},    bus.res_id,    port);
        check({tag, "_zero"},  bus.res_zero,  exp_z);
        check({tag, "_ovf"},   bus.res_ovf,   exp_o);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check({tag, "_valid_clr"}, bus.res_valid, 0);
    endtask

    initial begin
        int  n;
        bit  seen;
        int  exp_id;

        idle_inputs();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_valid",  bus.res_valid,  0);
        check("rst_data",   bus.res_data,   0);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a SUB
        bus.req0_a = 8'd3; bus.req0_b = 8'd1; bus.req0_sub = 1'b1; bus.req0_valid = 1'b1;
        @(negedge clk);
        check("midsub_ready", bus.req0_ready, 1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midsub_valid", bus.res_valid, 0);
        check("midsub_data",  bus.res_data,  0);
        check("midsub_id",    bus.res_id,    0);
        check("midsub_zero",  bus.res_zero,  0);
        check("midsub_ovf",   bus.res_ovf,   0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        check("midsub_never_valid", seen, 0);
        @(posedge clk);
        #1;
        bus.req0_a = 8'd0; bus.req0_b = 8'd0; bus.req0_sub = 1'b0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        @(negedge clk);
        check("midsub_ptr_r0", bus.req0_ready, 1);
        check("midsub_ptr_r1", bus.req1_ready, 0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors
        do_op("add_10_12",   1'b0, 8'd10, 8'd12, 1'b0, 8'd22,  1'b0, 1'b0);
        do_op("sub_5_5",     1'b1, 8'd5,  8'd5,  1'b1, 8'd0,   1'b1, 1'b0);
        do_op("add_7f_01",   1'b0, 8'h7F, 8'h01, 1'b0, 8'h80,  1'b0, 1'b1);
        do_op("sub_00_80",   1'b1, 8'h00, 8'h80, 1'b1, 8'h80,  1'b0, 1'b1);
        do_op("sub_ff_80",   1'b0, 8'hFF, 8'h80, 1'b1, 8'h7F,  1'b0, 1'b0);
        do_op("sub_20_30",   1'b1, 8'h20, 8'h30, 1'b1, 8'hF0,  1'b0, 1'b0);
        do_op("add_80_80",   1'b0, 8'h80, 8'h80, 1'b0, 8'h00,  1'b1, 1'b1);

        // Contention: both requesters valid continuously
        do_reset();
        bus.res_ready = 1'b1;
        bus.req0_a = 8'd1;  bus.req0_b = 8'd2;  bus.req0_sub = 1'b0; bus.req0_valid = 1'b1;
        bus.req1_a = 8'd10; bus.req1_b = 8'd20; bus.req1_sub = 1'b0; bus.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = i % 2;
            n = 0;
            @(negedge clk);
            while (!(bus.req0_ready || bus.req1_ready) && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("cont_gnt0", bus.req0_ready, (exp_id == 0));
            check("cont_gnt1", bus.req1_ready, (exp_id == 1));
            @(posedge clk);
            #1;
            n = 0;
            while (!bus.res_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("cont_valid", bus.res_valid, 1);
            check("cont_id",    bus.res_id,    exp_id);
            check("cont_data",  bus.res_data,  (exp_id == 1) ? 8'd30 : 8'd3);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        check("cont_exclusive", both_seen, 0);

        // Backpressure in HOLD with port 1 waiting
        do_reset();
        bus.req0_a = 8'h7F; bus.req0_b = 8'h01; bus.req0_sub = 1'b0; bus.req0_valid = 1'b1;
        @(negedge clk);
        check("bp_ready0", bus.req0_ready, 1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_a = 8'd9; bus.req1_b = 8'd3; bus.req1_sub = 1'b1; bus.req1_valid = 1'b1;
        n = 0;
        while (!bus.res_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_valid", bus.res_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", bus.res_valid,  1);
            check("bp_hold_data",  bus.res_data,   8'h80);
            check("bp_hold_ovf",   bus.res_ovf,    1);
            check("bp_hold_zero",  bus.res_zero,   0);
            check("bp_hold_id",    bus.res_id,     0);
            check("bp_hold_r1",    bus.req1_ready, 0);
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_r1", bus.req1_ready, 0);
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        check("bp_after_valid", bus.res_valid,  0);
        check("bp_after_r1",    bus.req1_ready, 1);
        @(posedge clk);
        #1 bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp_sub_valid", bus.res_valid, 1);
        check("bp_sub_data",  bus.res_data,  8'd6);
        check("bp_sub_id",    bus.res_id,    1);
        check("bp_sub_ovf",   bus.res_ovf,   0);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
